muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit, downstream of the register file.
- Consumes the two read-port operands (rd1/rd2) and the destination index of an M-extension instruction.
- Produces a single-cycle write request (address, enable, data) that drives register-file write port 3 (a3/we3/wd3).
- Multi-cycle; stalls the issue stage via in_ready.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  issue request valid
- in_ready  out  1  unit can accept a request; equals (state==IDLE)
- funct3  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  in  XLEN  rs1 value (register file rd1)
- op_b  in  XLEN  rs2 value (register file rd2)
- rd_in  in  5  destination register index
- flush  in  1  abort any in-flight operation
- out_valid  out  1  one-cycle result strobe; drives we3
- out_rd  out  5  destination index; drives a3
- out_data  out  XLEN  result; drives wd3

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, out_valid=0, out_rd=0, out_data=0; internal accumulators/counter cleared.
  - Reset mid-operation discards it; no out_valid follows.
- States: IDLE, CALC, DONE.
- Accept:
  - in_valid && in_ready sampled at a rising edge.
  - Latch funct3, rd_in, operands.
  - For signed ops, latch magnitudes and the result-sign flag.
- IDLE -> CALC on accept for normal ops; counter loaded with XLEN.
- CALC: one iteration per cycle, counter decrements; CALC -> DONE when the counter reaches 0.
  - Exactly XLEN CALC cycles.
- Multiply:
  - Radix-2 shift-add on a 2*XLEN product.
  - MUL returns the low word.
  - MULH/MULHSU/MULHU return the high word.
  - MULHSU: op_a signed, op_b unsigned.
  - Signed results negate the 2*XLEN magnitude product in the DONE transition.
- Divide:
  - Radix-2 restoring on magnitudes.
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
- Special cases (decided at accept, skip CALC, IDLE -> DONE directly):
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = op_a.
  - Signed overflow (DIV/REM, op_a = 0x80000000, op_b = 0xFFFFFFFF): DIV = 0x80000000; REM = 0.
- DONE:
  - out_valid=1 for exactly one cycle; out_rd/out_data valid.
  - DONE -> IDLE unconditionally.
  - in_ready=0 in DONE.
- Latency:
  - Normal op: out_valid is high in the (XLEN+1)th cycle after the accepting edge (33 for XLEN=32).
  - Special case: out_valid is high in the 1st cycle after accept.
- No output backpressure; the write port always accepts.
- out_rd=0 is legal; result is still computed and strobed.
- out_data/out_rd hold their last value when out_valid=0.
- flush:
  - Any state -> IDLE next edge; suppresses out_valid in that edge's following cycle.
  - flush with in_valid in IDLE: flush wins, no accept.
- Back-to-back: the next accept is possible at the edge ending DONE+1 cycle (in IDLE); no accept in DONE.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined:
  - All multiply ops compute combinationally from the operands with a full 2*XLEN signed/unsigned product.
  - Transition IDLE -> DONE at accept; out_valid high 1 cycle after accept.
  - Divide path unchanged.
- Undefined:
  - Multiply uses the iterative CALC path, XLEN+1 cycle latency.

Test Plan:
- MUL 7 * -3 (op_a=7, op_b=0xFFFFFFFD, rd_in=5) -> out_valid exactly once, 33 cycles after accept (1 cycle with MULDIV_FAST_MUL_EN), out_rd=5, out_data=0xFFFFFFEB.
- MULH 0x80000000 * 0x80000000 -> 0x40000000.
- MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE.
- MULHSU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2; each with 33-cycle latency and in_ready low throughout.
- DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000; REM -> 0; out_valid 1 cycle after accept.
- Assert flush 10 cycles into a DIV -> no out_valid ever for that op; in_ready high next cycle; a subsequent DIVU 9/3 returns 3.
- Pull rst_n low asynchronously mid-CALC (between edges) -> out_valid/out_data/out_rd immediately 0, in_ready 1 after release, no stale strobe.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit feeding register-file write port 3.
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiply; divide stays iterative.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            out_valid,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_data
);
    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    typedef struct packed {
        logic [2:0] op;
        logic [4:0] rd;
        logic       neg;
    } req_t;

    state_t            state;
    req_t              req;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc;   // mul: {partial hi, multiplier}; div: {remainder, dividend/quotient}
    logic [XLEN-1:0]   opnd;  // mul: multiplicand magnitude; div: divisor magnitude

    assign in_ready = (state == IDLE);

    // Accept-time operand decode
    logic            a_signed, b_signed, a_neg, b_neg, res_neg_in;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] a_mag, b_mag, special_data;

    always_comb begin
        a_signed   = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                     (funct3 == 3'b100) || (funct3 == 3'b110);
        b_signed   = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        a_neg      = a_signed & op_a[XLEN-1];
        b_neg      = b_signed & op_b[XLEN-1];
        a_mag      = a_neg ? -op_a : op_a;
        b_mag      = b_neg ? -op_b : op_b;
        // Remainder takes the dividend's sign; everything else the XOR
        res_neg_in = (funct3[2] && funct3[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero   = (op_b == '0);
        div_ovf    = !funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
        special    = funct3[2] && (div_zero || div_ovf);
        // Overflow quotient equals op_a (the most negative value)
        if (funct3[1]) special_data = div_zero ? op_a : '0;
        else           special_data = div_zero ? '1 : op_a;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
    assign fast_a    = {{XLEN{a_signed & op_a[XLEN-1]}}, op_a};
    assign fast_b    = {{XLEN{b_signed & op_b[XLEN-1]}}, op_b};
    assign fast_prod = fast_a * fast_b;
`endif

    // One radix-2 iteration and the result it would produce
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] mul_next, div_next, acc_next, mul_full;
    logic [XLEN-1:0]   div_val, calc_result;

    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next  = {mul_sum, acc[XLEN-1:1]};
        div_shift = acc[2*XLEN-1:XLEN-1];
        div_diff  = div_shift - {1'b0, opnd};
        div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        acc_next  = req.op[2] ? div_next : mul_next;

        mul_full  = req.neg ? -acc_next : acc_next;
        div_val   = req.op[1] ? acc_next[2*XLEN-1:XLEN] : acc_next[XLEN-1:0];
        if (req.neg) div_val = -div_val;

        if (req.op[2])              calc_result = div_val;
        else if (req.op[1:0] == '0) calc_result = mul_full[XLEN-1:0];
        else                        calc_result = mul_full[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req       <= '0;
            cnt       <= '0;
            acc       <= '0;
            opnd      <= '0;
            out_valid <= 1'b0;
            out_rd    <= '0;
            out_data  <= '0;
        end else begin
            out_valid <= 1'b0;
            if (flush) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (in_valid) begin
                        req.op  <= funct3;
                        req.rd  <= rd_in;
                        req.neg <= res_neg_in;
                        if (special) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_rd    <= rd_in;
                            out_data  <= special_data;
`ifdef MULDIV_FAST_MUL_EN
                        end else if (!funct3[2]) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_rd    <= rd_in;
                            out_data  <= (funct3[1:0] == 2'b00) ? fast_prod[XLEN-1:0]
                                                                : fast_prod[2*XLEN-1:XLEN];
`endif
                        end else begin
                            state <= CALC;
                            cnt   <= CW'(XLEN);
                            acc   <= {{XLEN{1'b0}}, (funct3[2] ? a_mag : b_mag)};
                            opnd  <= funct3[2] ? b_mag : a_mag;
                        end
                    end
                    CALC: begin
                        acc <= acc_next;
                        cnt <= cnt - 1'b1;
                        if (cnt == CW'(1)) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_rd    <= req.rd;
                            out_data  <= calc_result;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (honours MULDIV_FAST_MUL_EN for multiply latency).
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, flush, in_ready, out_valid;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b, out_data;
    logic [4:0]  rd_in, out_rd;
    int          tests = 0;
    int          fails = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .flush(flush),
        .out_valid(out_valid), .out_rd(out_rd), .out_data(out_data)
    );

    always #5 clk = ~clk;

    // Issues one op from an idle unit and observes a fixed 60-cycle window.
    // lat = cycle index after the accepting edge in which out_valid was first high.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output logic [31:0] data, output logic [4:0] rdo,
                          output int lat, output int pulses, output bit busy_ok);
        funct3 = f; op_a = a; op_b = b; rd_in = rd; in_valid = 1'b1;
        data = '0; rdo = '0; lat = 0; pulses = 0; busy_ok = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            if (pulses == 0 && in_ready !== 1'b0) busy_ok = 1'b0;
            if (out_valid === 1'b1) begin
                if (pulses == 0) begin lat = k; data = out_data; rdo = out_rd; end
                pulses++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        tests += 4;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
        if (out_data !== 32'h0) begin fails++; $display("FAIL reset out_data: got %h want 0", out_data); end
        if (out_rd !== 5'h0)    begin fails++; $display("FAIL reset out_rd: got %0d want 0", out_rd); end
        if (in_ready !== 1'b1)  begin fails++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    endtask

    task automatic check_ops(input string tag, input logic [2:0] f[4], input logic [31:0] a[4],
                             input logic [31:0] b[4], input logic [4:0] rd[4],
                             input logic [31:0] exp_d[4], input int exp_lat);
        logic [31:0] d; logic [4:0] r; int lat, np; bit busy;
        for (int i = 0; i < 4; i++) begin
            run_op(f[i], a[i], b[i], rd[i], d, r, lat, np, busy);
            tests += 5;
            if (d !== exp_d[i]) begin fails++; $display("FAIL %s[%0d] data: got %h want %h", tag, i, d, exp_d[i]); end
            if (r !== rd[i])    begin fails++; $display("FAIL %s[%0d] rd: got %0d want %0d", tag, i, r, rd[i]); end
            if (lat != exp_lat) begin fails++; $display("FAIL %s[%0d] latency: got %0d want %0d", tag, i, lat, exp_lat); end
            if (np != 1)        begin fails++; $display("FAIL %s[%0d] strobes: got %0d want 1", tag, i, np); end
            if (!busy)          begin fails++; $display("FAIL %s[%0d] in_ready high while busy", tag, i); end
        end
    endtask

    task automatic test_mul;
        check_ops("mul", '{3'b000, 3'b001, 3'b011, 3'b010},
                  '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
                  '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
                  '{5'd5, 5'd6, 5'd0, 5'd7},
                  '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF}, MUL_LAT);
    endtask

    task automatic test_div;
        check_ops("div", '{3'b100, 3'b110, 3'b101, 3'b111},
                  '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100},
                  '{32'd2, 32'd2, 32'd7, 32'd7},
                  '{5'd1, 5'd2, 5'd3, 5'd4},
                  '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2}, 33);
    endtask

    task automatic test_special;
        check_ops("special", '{3'b101, 3'b110, 3'b100, 3'b110},
                  '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000},
                  '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
                  '{5'd8, 5'd9, 5'd10, 5'd11},
                  '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0}, 1);
    endtask

    task automatic test_flush;
        int np = 0;
        logic [31:0] d; logic [4:0] r; int lat; bit busy;
        funct3 = 3'b100; op_a = 32'd1000; op_b = 32'd3; rd_in = 5'd12; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL flush in_ready: got %b want 1", in_ready); end
        for (int k = 0; k < 40; k++) begin
            if (out_valid === 1'b1) np++;
            @(posedge clk); #1;
        end
        tests++;
        if (np != 0) begin fails++; $display("FAIL flush strobes: got %0d want 0", np); end
        // flush beats a simultaneous request in IDLE
        funct3 = 3'b101; op_a = 32'd5; op_b = 32'd0; rd_in = 5'd13; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        np = 0;
        for (int k = 0; k < 3; k++) begin
            if (out_valid === 1'b1) np++;
            @(posedge clk); #1;
        end
        tests++;
        if (np != 0) begin fails++; $display("FAIL flush-vs-accept strobes: got %0d want 0", np); end
        run_op(3'b101, 32'd9, 32'd3, 5'd14, d, r, lat, np, busy);
        tests += 2;
        if (d !== 32'd3) begin fails++; $display("FAIL post-flush divu data: got %h want 3", d); end
        if (lat != 33)   begin fails++; $display("FAIL post-flush divu latency: got %0d want 33", lat); end
    endtask

    task automatic test_back_to_back;
        funct3 = 3'b101; op_a = 32'd5; op_b = 32'd0; rd_in = 5'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b1) begin fails++; $display("FAIL b2b first strobe: got %b want 1", out_valid); end
        @(posedge clk); #1;
        tests += 2;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b accept in DONE: got %b want 0", out_valid); end
        if (in_ready !== 1'b1)  begin fails++; $display("FAIL b2b in_ready after DONE: got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1) begin fails++; $display("FAIL b2b second strobe: got %b want 1", out_valid); end
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b strobe width: got %b want 0", out_valid); end
    endtask

    task automatic test_async_reset;
        int np = 0;
        funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd9; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        tests += 3;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL async reset out_valid: got %b want 0", out_valid); end
        if (out_data !== 32'h0) begin fails++; $display("FAIL async reset out_data: got %h want 0", out_data); end
        if (out_rd !== 5'h0)    begin fails++; $display("FAIL async reset out_rd: got %0d want 0", out_rd); end
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL async reset in_ready: got %b want 1", in_ready); end
        for (int k = 0; k < 40; k++) begin
            if (out_valid === 1'b1) np++;
            @(posedge clk); #1;
        end
        tests++;
        if (np != 0) begin fails++; $display("FAIL async reset stale strobes: got %0d want 0", np); end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0;
        funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;
        #12;
        test_reset;
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        test_mul;
        test_div;
        test_special;
        test_flush;
        test_back_to_back;
        test_async_reset;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
